// File: rtl/bcd_counter_sseg.sv
// rtl/bcd_counter_sseg.sv - four-digit up/down BCD counter with active-low segment outputs
module bcd_counter_sseg #(
   parameter int BLANK_LZ = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   input  logic        dec,
   input  logic        clr,
   input  logic [3:0]  dp,
   output logic [15:0] bcd,
   output logic [7:0]  sseg3,
   output logic [7:0]  sseg2,
   output logic [7:0]  sseg1,
   output logic [7:0]  sseg0,
   output logic        ovf,
   output logic        unf
);

   localparam logic [7:0] SSEG_HI_RST = (BLANK_LZ != 0) ? 8'hFF : 8'hC0;

   // Request vector layout: bit 0 inc, bit 1 dec, bit 2 clr.
   logic [2:0] s1, s2, s3;
   logic [2:0] pulse;
   assign pulse = s2 & ~s3;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 3'b000;
         s2 <= 3'b000;
         s3 <= 3'b000;
      end else begin
         s1 <= {clr, dec, inc};
         s2 <= s1;
         s3 <= s2;
      end
   end

   logic [15:0] bcd_inc, bcd_dec;
   logic        carry, borrow;

   // Ripple through digits; a leftover carry/borrow out of digit 3 is the wrap.
   always_comb begin
      bcd_inc = bcd;
      bcd_dec = bcd;
      carry   = 1'b1;
      borrow  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (bcd[4*i +: 4] == 4'd9) begin
               bcd_inc[4*i +: 4] = 4'd0;
            end else begin
               bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (bcd[4*i +: 4] == 4'd0) begin
               bcd_dec[4*i +: 4] = 4'd9;
            end else begin
               bcd_dec[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcd <= 16'h0000;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         ovf <= 1'b0;
         unf <= 1'b0;
         if (pulse[2]) begin
            bcd <= 16'h0000;
         end else if (pulse[0] && !pulse[1]) begin
            bcd <= bcd_inc;
            ovf <= carry;
         end else if (pulse[1] && !pulse[0]) begin
            bcd <= bcd_dec;
            unf <= borrow;
         end
      end
   end

   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      case (d)
         4'd0:    seg_enc = 7'h40;
         4'd1:    seg_enc = 7'h79;
         4'd2:    seg_enc = 7'h24;
         4'd3:    seg_enc = 7'h30;
         4'd4:    seg_enc = 7'h19;
         4'd5:    seg_enc = 7'h12;
         4'd6:    seg_enc = 7'h02;
         4'd7:    seg_enc = 7'h78;
         4'd8:    seg_enc = 7'h00;
         4'd9:    seg_enc = 7'h10;
         default: seg_enc = 7'h7F;
      endcase
   endfunction

   logic [3:0] blank;
   assign blank[3] = (BLANK_LZ != 0) && (bcd[15:12] == 4'd0);
   assign blank[2] = blank[3] && (bcd[11:8] == 4'd0);
   assign blank[1] = blank[2] && (bcd[7:4] == 4'd0);
   assign blank[0] = 1'b0;

   logic [3:0][7:0] sseg_q;

   // Decimal point is active-low and survives blanking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sseg_q[3] <= SSEG_HI_RST;
         sseg_q[2] <= SSEG_HI_RST;
         sseg_q[1] <= SSEG_HI_RST;
         sseg_q[0] <= 8'hC0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            sseg_q[i] <= {~dp[i], blank[i] ? 7'h7F : seg_enc(bcd[4*i +: 4])};
         end
      end
   end

   assign sseg3 = sseg_q[3];
   assign sseg2 = sseg_q[2];
   assign sseg1 = sseg_q[1];
   assign sseg0 = sseg_q[0];

endmodule

// File: tb/tb_bcd_counter_sseg.sv
// tb/tb_bcd_counter_sseg.sv - directed self-checking bench for bcd_counter_sseg
module tb_bcd_counter_sseg;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        inc = 1'b0;
   logic        dec = 1'b0;
   logic        clr = 1'b0;
   logic [3:0]  dp = 4'b0000;
   logic [15:0] bcd, bcd_nb;
   logic [7:0]  sseg3, sseg2, sseg1, sseg0;
   logic [7:0]  nb3, nb2, nb1, nb0;
   logic        ovf, unf, ovf_nb, unf_nb;

   int checks = 0;
   int failures = 0;

   logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   always #10 clk = ~clk;

   bcd_counter_sseg #(.BLANK_LZ(1)) dut (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clr(clr), .dp(dp),
      .bcd(bcd), .sseg3(sseg3), .sseg2(sseg2), .sseg1(sseg1), .sseg0(sseg0),
      .ovf(ovf), .unf(unf)
   );

   bcd_counter_sseg #(.BLANK_LZ(0)) dut_nb (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clr(clr), .dp(dp),
      .bcd(bcd_nb), .sseg3(nb3), .sseg2(nb2), .sseg1(nb1), .sseg0(nb0),
      .ovf(ovf_nb), .unf(unf_nb)
   );

   function automatic logic [15:0] to_bcd(input int n);
      to_bcd = {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Raise the requested inputs for 4 edges, check bcd at k+1/k+2 and sseg0 at k+2/k+3.
   task automatic act(input string tag, input logic i_v, input logic d_v, input logic c_v,
                      input logic [15:0] old_v, input logic [15:0] new_v,
                      input logic eo, input logic eu,
                      input logic [7:0] s0_old, input logic [7:0] s0_new);
      @(negedge clk);
      inc = i_v; dec = d_v; clr = c_v;
      @(posedge clk);
      @(posedge clk); #1;
      chk({tag, "_k1_bcd"}, bcd, old_v);
      chk({tag, "_k1_flags"}, {14'd0, ovf, unf}, 16'd0);
      @(posedge clk); #1;
      chk({tag, "_k2_bcd"}, bcd, new_v);
      chk({tag, "_k2_flags"}, {14'd0, ovf, unf}, {14'd0, eo, eu});
      chk({tag, "_k2_sseg0"}, {8'd0, sseg0}, {8'd0, s0_old});
      @(posedge clk); #1;
      chk({tag, "_k3_sseg0"}, {8'd0, sseg0}, {8'd0, s0_new});
      chk({tag, "_k3_flags"}, {14'd0, ovf, unf}, 16'd0);
      @(negedge clk);
      inc = 1'b0; dec = 1'b0; clr = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #2 reset = 1'b1;
      #1;
      chk("rst_bcd", bcd, 16'h0000);
      chk("rst_sseg32", {sseg3, sseg2}, 16'hFFFF);
      chk("rst_sseg10", {sseg1, sseg0}, 16'hFFC0);
      chk("rst_flags", {14'd0, ovf, unf}, 16'd0);
      chk("rst_nb_sseg32", {nb3, nb2}, 16'hC0C0);
      chk("rst_nb_sseg10", {nb1, nb0}, 16'hC0C0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 10; i++)
         act("inc", 1'b1, 1'b0, 1'b0, to_bcd(i), to_bcd(i + 1), 1'b0, 1'b0,
             lut[i % 10], lut[(i + 1) % 10]);
      chk("ten_bcd", bcd, 16'h0010);
      chk("ten_sseg32", {sseg3, sseg2}, 16'hFFFF);
      chk("ten_sseg10", {sseg1, sseg0}, 16'hF9C0);
      chk("ten_nb_sseg32", {nb3, nb2}, 16'hC0C0);
      chk("ten_nb_sseg10", {nb1, nb0}, 16'hF9C0);

      act("clr_inc", 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b0, 8'hC0, 8'hC0);
      act("dec_unf", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b0, 1'b1, 8'hC0, 8'h90);
      chk("unf_sseg32", {sseg3, sseg2}, 16'h9090);
      chk("unf_sseg1", {8'd0, sseg1}, 16'h0090);
      act("dec_borrow", 1'b0, 1'b1, 1'b0, 16'h9999, 16'h9998, 1'b0, 1'b0, 8'h90, 8'h80);
      act("inc_9999", 1'b1, 1'b0, 1'b0, 16'h9998, 16'h9999, 1'b0, 1'b0, 8'h80, 8'h90);
      act("inc_ovf", 1'b1, 1'b0, 1'b0, 16'h9999, 16'h0000, 1'b1, 1'b0, 8'h90, 8'hC0);
      chk("ovf_sseg32", {sseg3, sseg2}, 16'hFFFF);

      for (int i = 0; i < 42; i++)
         act("inc42", 1'b1, 1'b0, 1'b0, to_bcd(i), to_bcd(i + 1), 1'b0, 1'b0,
             lut[i % 10], lut[(i + 1) % 10]);
      act("inc_dec", 1'b1, 1'b1, 1'b0, 16'h0042, 16'h0042, 1'b0, 1'b0, 8'hA4, 8'hA4);
      act("clr", 1'b0, 1'b0, 1'b1, 16'h0042, 16'h0000, 1'b0, 1'b0, 8'hA4, 8'hC0);

      for (int i = 0; i < 7; i++)
         act("inc7", 1'b1, 1'b0, 1'b0, to_bcd(i), to_bcd(i + 1), 1'b0, 1'b0,
             lut[i], lut[i + 1]);
      @(negedge clk);
      dp = 4'b0100;
      @(posedge clk); #1;
      chk("dp_sseg32", {sseg3, sseg2}, 16'hFF7F);
      chk("dp_sseg10", {sseg1, sseg0}, 16'hFFF8);
      @(negedge clk);
      dp = 4'b0000;
      @(posedge clk); #1;
      chk("dp_off_sseg2", {8'd0, sseg2}, 16'h00FF);

      @(negedge clk);
      inc = 1'b1;
      repeat (100) @(negedge clk);
      chk("held_bcd", bcd, 16'h0008);
      inc = 1'b0;
      repeat (5) @(negedge clk);
      chk("held_after_bcd", bcd, 16'h0008);

      inc = 1'b1;
      repeat (10) @(negedge clk);
      chk("hold2_bcd", bcd, 16'h0009);
      #3 reset = 1'b1;
      #1;
      chk("midrst_bcd", bcd, 16'h0000);
      chk("midrst_sseg20", {sseg2, sseg0}, 16'hFFC0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("postrst_bcd", bcd, 16'h0001);
      chk("postrst_sseg10", {sseg1, sseg0}, 16'hFFF9);
      chk("postrst_nb_sseg10", {nb1, nb0}, 16'hC0F9);
      inc = 1'b0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_counter_sseg.md
# bcd_counter_sseg

Four-digit up/down BCD counter with segment encoding. It converts asynchronous increment, decrement and clear requests into a 0000–9999 decimal count. It drives four 8-bit active-low segment patterns directly into the four-digit time-multiplexed display driver's `in3..in0` inputs. The block sits immediately upstream of that driver and shares its clock and reset.

## Interface
Parameters:
- `BLANK_LZ`, default 1: when 1, leading zeros are blanked; when 0, all four digits are always shown.

Ports:
- `clk`  in  1: system clock (50 MHz).
- `reset`  in  1: asynchronous, active-high.
- `inc`  in  1: increment request, asynchronous level, debounced externally; acts on the rising edge.
- `dec`  in  1: decrement request, asynchronous level, debounced externally; acts on the rising edge.
- `clr`  in  1: clear request, asynchronous level; acts on the rising edge.
- `dp`  in  4: decimal-point enables per digit, active-high, synchronous to `clk`; `dp[i]` maps to digit i.
- `bcd`  out  16: registered count, `{d3,d2,d1,d0}`, each a 4-bit BCD digit.
- `sseg3`, `sseg2`, `sseg1`, `sseg0`  out  8 each: registered segment patterns, active-low, bit order `{dp,g,f,e,d,c,b,a}`.
- `ovf`  out  1: one-cycle pulse on wrap from 9999 to 0000.
- `unf`  out  1: one-cycle pulse on wrap from 0000 to 9999.

## Operation
- **Synchronizers.** `inc`, `dec` and `clr` each pass through a 2-flop synchronizer (s1, s2) followed by a history flop (s3). The edge pulse for each is `s2 & ~s3`.
- **Count update priority.** The count updates on the clock edge where pulses are evaluated:
  - Clear pulse: count becomes 0000. Clear overrides inc/dec. No `ovf`/`unf`.
  - Inc pulse only: BCD increment. A digit at 9 becomes 0 and carries into the next digit. 9999 becomes 0000 and asserts `ovf`.
  - Dec pulse only: BCD decrement. A digit at 0 becomes 9 and borrows from the next digit. 0000 becomes 9999 and asserts `unf`.
  - Inc and dec pulses in the same cycle: no change, no flags.
- **Digit range.** Each digit stays within 0–9 at all times; codes A–F never appear on `bcd`.
- **Segment encoding.** `{g..a}` for digits 0–9 with dp off, in hex: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90. A blank digit is FF.
- **Blanking.** When `BLANK_LZ`=1, digit i (i=3..1) is blank if it and every higher digit are 0. Digit 0 is never blanked.
- **Decimal point.** Segment bit 7 equals `~dp[i]`. It applies even on a blank digit, so a blank digit with `dp[i]`=1 reads 7F.
- **Flags.** `ovf` and `unf` are registered and high for exactly one cycle per wrap.

## Timing
- **Input latency.** An input rising edge first sampled high at clock edge k gives:
  - s1=1 at edge k and s2=1 at edge k+1, so the pulse is high during cycle k+1..k+2.
  - `bcd`, `ovf` and `unf` update at edge k+2.
  - `sseg*` reflect the new count at edge k+3.
- **Decimal-point latency.** `dp` is registered into the `sseg*` register, one cycle of latency.
- **Held inputs.** An input held high produces exactly one action. A fresh action requires low for at least 2 cycles, then high again.
- **Reset values.** On asserting `reset`, immediately:
  - synchronizers and history flops = 0;
  - `bcd` = 0000, `ovf` = `unf` = 0;
  - `sseg0` = C0;
  - `sseg3..sseg1` = FF when `BLANK_LZ`=1, else C0.
- **Reset mid-operation.** A pending pulse is discarded. An input still high after reset releases counts once, since the history flop restarts at 0.
- **No combinational paths.** Outputs have no combinational path from any input.

## Test plan
- **Reset state.** Reset with `BLANK_LZ`=1 and `dp`=0 -> `bcd`=0000, `sseg3..0` = FF, FF, FF, C0, `ovf`=`unf`=0.
- **Increment latency and carry.** 10 inc pulses from 0000, each high 4 cycles and low 4 cycles:
  - `bcd`=0010;
  - `sseg3..0` = FF, FF, F9, C0;
  - each count change occurs 2 edges after the input rises;
  - `sseg` follows one edge later.
- **Overflow.** Preload to 9999 via 9999 increments (or a force in the bench), then one inc -> `bcd`=0000, `ovf` high exactly 1 cycle, `sseg0`=C0.
- **Underflow and borrow.**
  - From 0000, one dec -> `bcd`=9999, `unf` high 1 cycle, all `sseg`=90.
  - Then one dec -> `bcd`=9998, `sseg0`=80.
- **Simultaneous events.**
  - inc and dec rise in the same cycle at count 0042 -> no change, no flags.
  - clr with inc in the same cycle -> `bcd`=0000.
- **Decimal point and held input.**
  - `dp`=4'b0100 at count 0007 -> `sseg2`=7F, `sseg0`=F8.
  - inc held high for 100 cycles -> exactly one increment.
  - Assert reset mid-hold, then release with inc still high -> one increment after release.
